// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
//   Shared definitions for the round-robin bus arbiter:
//   - FSM state encoding (IDLE..RELEASE)
//   - watchdog counter width and its all-ones maximum
//   - owner index width (up to 8 masters)
//   - helper that tells whether a timeout value fits in the counter
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int BUS_ARB_CNT_W = 13;
    localparam int BUS_ARB_IDX_W = 3;

    localparam logic [BUS_ARB_CNT_W-1:0] BUS_ARB_CNT_MAX = {BUS_ARB_CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GRANT      = 3'd1,
        ST_WAIT_BEGIN = 3'd2,
        ST_BUSY       = 3'd3,
        ST_RELEASE    = 3'd4
    } bus_arb_state_e;

    // A timeout of N cycles is detected at count N-1, so N must be 1..max.
    function automatic logic bus_arb_fits_cnt(input int value);
        return (value >= 1) && (value <= int'(BUS_ARB_CNT_MAX));
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_checker.sv
// -----------------------------------------------------------------------------
// bus_arb_checker
//   Run-time assertions for bus_arbiter_rr: parameter ranges, counter fit,
//   grant vector at most one-hot, no grant while the bus is idle.
//   Ports: clock, reset, busGrants, busIdle (all inputs, observed only).
// -----------------------------------------------------------------------------
module bus_arb_checker
    import bus_arb_pkg::*;
#(
    parameter int nrOfMasters  = 4,
    parameter int beginTimeout = 16,
    parameter int busTimeout   = 4096
) (
    input logic                   clock,
    input logic                   reset,
    input logic [nrOfMasters-1:0] busGrants,
    input logic                   busIdle
);

    // Parameter and grant-shape checks, evaluated every cycle outside reset
    always @(posedge clock) begin
        if (!reset) begin
            assert ((nrOfMasters >= 2) && (nrOfMasters <= 8));
            assert (bus_arb_fits_cnt(beginTimeout) && bus_arb_fits_cnt(busTimeout));
            assert ($onehot0(busGrants));
            assert (!(busIdle && (busGrants != {nrOfMasters{1'b0}})));
        end
    end

endmodule

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selection: the first requester at or after the
//   priority pointer, wrapping cyclically.
//   Ports:
//     requests     in   nrOfMasters   request levels
//     pointer      in   3             highest-priority master index
//     winnerOnehot out  nrOfMasters   one-hot winner (zero if no request)
//     winnerIdx    out  3             binary index of the winner
//     anyRequest   out  1             at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int nrOfMasters = 4
) (
    input  logic [nrOfMasters-1:0]   requests,
    input  logic [BUS_ARB_IDX_W-1:0] pointer,
    output logic [nrOfMasters-1:0]   winnerOnehot,
    output logic [BUS_ARB_IDX_W-1:0] winnerIdx,
    output logic                     anyRequest
);

    logic [nrOfMasters-1:0] upper_mask_s;
    logic [nrOfMasters-1:0] upper_req_s;
    logic [nrOfMasters-1:0] pick_from_s;

    // Requesters at or above the pointer take precedence; if there are none the
    // search wraps to the full vector. Lowest set bit = x & -x.
    assign upper_mask_s = ~((nrOfMasters'(1) << pointer) - nrOfMasters'(1));
    assign upper_req_s  = requests & upper_mask_s;
    assign pick_from_s  = (upper_req_s != {nrOfMasters{1'b0}}) ? upper_req_s : requests;
    assign winnerOnehot = pick_from_s & (~pick_from_s + nrOfMasters'(1));
    assign anyRequest   = |requests;

    // One-hot to binary index conversion of the winner
    always_comb begin
        winnerIdx = {BUS_ARB_IDX_W{1'b0}};
        for (int j = 0; j < nrOfMasters; j++) begin
            winnerIdx = winnerOnehot[j] ? BUS_ARB_IDX_W'(j) : winnerIdx;
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter for the shared system bus with begin/end tracking and
//   two watchdogs (grant-without-begin, transaction-without-end).
//   Ports:
//     clock, reset (sync, active-high)
//     busRequests        in   per-master request level
//     busGrants          out  one-hot single-cycle grant pulse (also mux select)
//     beginTransactionIn in   OR of all masters' begin strobes
//     endTransactionIn   in   OR of all masters' end strobes
//     busErrorIn         in   slave-side error
//     busErrorOut        out  registered (busErrorIn while owned) | watchdog pulse
//     activeMaster       out  owner index, valid while busIdle=0
//     busIdle            out  1 when no master owns the bus
//   Timing: WAIT_BEGIN lasts at most beginTimeout cycles; BUSY raises the
//   watchdog after busTimeout cycles and gives up after a second busTimeout.
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int nrOfMasters  = 4,
    parameter int beginTimeout = 16,
    parameter int busTimeout   = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [nrOfMasters-1:0] busRequests,
    output logic [nrOfMasters-1:0] busGrants,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   busErrorIn,
    output logic                   busErrorOut,
    output logic [2:0]             activeMaster,
    output logic                   busIdle
);
    import bus_arb_pkg::*;

    localparam logic [BUS_ARB_CNT_W-1:0] BEGIN_LAST = BUS_ARB_CNT_W'(beginTimeout - 1);
    localparam logic [BUS_ARB_CNT_W-1:0] BUS_LAST   = BUS_ARB_CNT_W'(busTimeout - 1);
    localparam logic [BUS_ARB_IDX_W-1:0] LAST_IDX   = BUS_ARB_IDX_W'(nrOfMasters - 1);

    bus_arb_state_e             state_r, state_next_s;
    logic [BUS_ARB_CNT_W-1:0]   cnt_r;
    logic                       timed_out_r;
    logic [BUS_ARB_IDX_W-1:0]   pointer_r, pointer_next_s;
    logic [nrOfMasters-1:0]     grants_r, grants_next_s;
    logic [BUS_ARB_IDX_W-1:0]   active_r, active_next_s;
    logic                       idle_r, idle_next_s;
    logic                       err_r, err_next_s;
    logic [nrOfMasters-1:0]     winner_onehot_s;
    logic [BUS_ARB_IDX_W-1:0]   winner_idx_s;
    logic                       any_request_s;
    logic                       begin_expired_s, bus_expired_s, wd_pulse_s;

    rr_picker #(.nrOfMasters(nrOfMasters)) u_picker (
        .requests     (busRequests),
        .pointer      (pointer_r),
        .winnerOnehot (winner_onehot_s),
        .winnerIdx    (winner_idx_s),
        .anyRequest   (any_request_s)
    );

    bus_arb_checker #(
        .nrOfMasters  (nrOfMasters),
        .beginTimeout (beginTimeout),
        .busTimeout   (busTimeout)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .busGrants (grants_r),
        .busIdle   (idle_r)
    );

    assign begin_expired_s = (cnt_r == BEGIN_LAST);
    assign bus_expired_s   = (cnt_r == BUS_LAST);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; also decides the one-shot watchdog pulse in BUSY
    always_comb begin
        state_next_s = state_r;
        wd_pulse_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_request_s) begin
                    state_next_s = ST_GRANT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_next_s = ST_WAIT_BEGIN;
            end
            ST_WAIT_BEGIN: begin
                // begin and end in one cycle is a complete zero-length transfer
                if (beginTransactionIn && endTransactionIn) begin
                    state_next_s = ST_RELEASE;
                end else if (beginTransactionIn) begin
                    state_next_s = ST_BUSY;
                end else if (begin_expired_s) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_WAIT_BEGIN;
                end
            end
            ST_BUSY: begin
                // an end coinciding with the expiry wins: release, no error
                if (endTransactionIn) begin
                    state_next_s = ST_RELEASE;
                end else if (bus_expired_s && timed_out_r) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_BUSY;
                    wd_pulse_s   = bus_expired_s & ~timed_out_r;
                end
            end
            ST_RELEASE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Watchdog counter: saturating, cleared on state entry and restarted
    // after the first BUSY expiry so the second expiry measures a full period
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r       <= {BUS_ARB_CNT_W{1'b0}};
            timed_out_r <= 1'b0;
        end else if (state_next_s != state_r) begin
            cnt_r       <= {BUS_ARB_CNT_W{1'b0}};
            timed_out_r <= 1'b0;
        end else if (wd_pulse_s) begin
            cnt_r       <= {BUS_ARB_CNT_W{1'b0}};
            timed_out_r <= 1'b1;
        end else if (cnt_r != BUS_ARB_CNT_MAX) begin
            cnt_r       <= cnt_r + BUS_ARB_CNT_W'(1);
            timed_out_r <= timed_out_r;
        end else begin
            cnt_r       <= cnt_r;
            timed_out_r <= timed_out_r;
        end
    end

    // Output next-values: grant pulse leaving IDLE, pointer update in GRANT
    always_comb begin
        grants_next_s  = {nrOfMasters{1'b0}};
        active_next_s  = active_r;
        pointer_next_s = pointer_r;
        if ((state_r == ST_IDLE) && any_request_s) begin
            grants_next_s = winner_onehot_s;
            active_next_s = winner_idx_s;
        end else begin
            grants_next_s = {nrOfMasters{1'b0}};
            active_next_s = active_r;
        end
        if (state_r == ST_GRANT) begin
            pointer_next_s = (active_r == LAST_IDX) ? {BUS_ARB_IDX_W{1'b0}}
                                                    : active_r + BUS_ARB_IDX_W'(1);
        end else begin
            pointer_next_s = pointer_r;
        end
        idle_next_s = (state_next_s == ST_IDLE) || (state_next_s == ST_RELEASE);
        err_next_s  = (busErrorIn & ~idle_r) | wd_pulse_s;
    end

    // Output and pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            grants_r  <= {nrOfMasters{1'b0}};
            active_r  <= {BUS_ARB_IDX_W{1'b0}};
            pointer_r <= {BUS_ARB_IDX_W{1'b0}};
            idle_r    <= 1'b1;
            err_r     <= 1'b0;
        end else begin
            grants_r  <= grants_next_s;
            active_r  <= active_next_s;
            pointer_r <= pointer_next_s;
            idle_r    <= idle_next_s;
            err_r     <= err_next_s;
        end
    end

    assign busGrants    = grants_r;
    assign activeMaster = active_r;
    assign busIdle      = idle_r;
    assign busErrorOut  = err_r;

endmodule
